score_frame_rx: RTL and testbench

- Receive-side frame decoder for the inter-board score link. It is the far end of the per-link byte stream produced by the score transmitter.
- Consumes the UART receiver byte strobe and byte. Reassembles one framed 24-bit BCD score, validates it, and presents it to the character ROM as the opponent score.
- One instance per UART link.

---
 rtl/score_link_pkg.sv | 35 +++
 rtl/score_rx_timeout.sv | 30 +++
 rtl/score_frame_rx.sv | 89 ++++++++
 tb/tb_score_frame_rx.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/score_link_pkg.sv
// rtl/score_link_pkg.sv - shared constants, state encoding and checksum for the score link
// Used by both transmit and receive ends; the BCD helper backs SCORE_RX_BCD_CHECK_EN.
package score_link_pkg;

  localparam logic [7:0] HDR_BYTE_DEF = 8'hA5;
  localparam int         FRAME_LEN    = 5;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_GET_P2  = 3'd1;
  localparam logic [2:0] ST_GET_P1  = 3'd2;
  localparam logic [2:0] ST_GET_P0  = 3'd3;
  localparam logic [2:0] ST_GET_CHK = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    GET_P2  = ST_GET_P2,
    GET_P1  = ST_GET_P1,
    GET_P0  = ST_GET_P0,
    GET_CHK = ST_GET_CHK
  } rx_state_t;

  function automatic logic [7:0] score_chk(input logic [23:0] score);
    return score[23:16] ^ score[15:8] ^ score[7:0];
  endfunction

  function automatic logic is_bcd_score(input logic [23:0] score);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (score[i*4 +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/score_rx_timeout.sv
// rtl/score_rx_timeout.sv - saturating inter-byte gap counter for the score frame receiver
module score_rx_timeout #(
  parameter int TIMEOUT_CYC = 75000
) (
  input  logic pclk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] count;

  assign expired = (count == LAST);

  // Holds at LAST so a stalled frame keeps reporting expiry until the FSM idles.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (run && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/score_frame_rx.sv
// rtl/score_frame_rx.sv - decodes HDR,P2,P1,P0,CHK frames into the opponent BCD score
// Define SCORE_RX_BCD_CHECK_EN to also reject checksum-valid frames with non-BCD digits.
module score_frame_rx
  import score_link_pkg::*;
#(
  parameter logic [7:0]  HDR_BYTE    = HDR_BYTE_DEF,
  parameter int          TIMEOUT_CYC = 75000,
  parameter logic [23:0] RST_SCORE   = 24'h000000
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        rx_done_tick,
  input  logic [7:0]  rx_data,
  output logic [23:0] score_out,
  output logic        score_valid,
  output logic        frame_err,
  output logic        busy
);

  rx_state_t   state;
  logic [23:0] payload;
  logic        expired;
  logic        digits_ok;

  score_rx_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .pclk    (pclk),
    .rst     (rst),
    .clear   (rx_done_tick || (state == IDLE)),
    .run     (state != IDLE),
    .expired (expired)
  );

`ifdef SCORE_RX_BCD_CHECK_EN
  assign digits_ok = is_bcd_score(payload);
`else
  assign digits_ok = 1'b1;
`endif

  assign busy = (state != IDLE);

  // A strobe always takes priority over expiry, so a byte landing on the last cycle is kept.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      payload     <= '0;
      score_out   <= RST_SCORE;
      score_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      score_valid <= 1'b0;
      frame_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_done_tick && rx_data == HDR_BYTE) state <= GET_P2;
        end
        GET_P2, GET_P1, GET_P0: begin
          if (rx_done_tick) begin
            case (state)
              GET_P2:  begin payload[23:16] <= rx_data; state <= GET_P1;  end
              GET_P1:  begin payload[15:8]  <= rx_data; state <= GET_P0;  end
              default: begin payload[7:0]   <= rx_data; state <= GET_CHK; end
            endcase
          end else if (expired) begin
            state     <= IDLE;
            payload   <= '0;
            frame_err <= 1'b1;
          end
        end
        GET_CHK: begin
          if (rx_done_tick) begin
            if (rx_data == score_chk(payload) && digits_ok) begin
              score_out   <= payload;
              score_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            state <= IDLE;
          end else if (expired) begin
            state     <= IDLE;
            payload   <= '0;
            frame_err <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_score_frame_rx.sv
// tb/tb_score_frame_rx.sv - table, directed and random checks of score_frame_rx against a frame model
module tb_score_frame_rx;

  localparam int T = 16;

  logic        pclk = 1'b0;
  logic        rst  = 1'b1;
  logic        rx_done_tick = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic [23:0] score_out;
  logic        score_valid;
  logic        frame_err;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  score_frame_rx #(.HDR_BYTE(8'hA5), .TIMEOUT_CYC(T), .RST_SCORE(24'h000000)) dut (
    .pclk         (pclk),
    .rst          (rst),
    .rx_done_tick (rx_done_tick),
    .rx_data      (rx_data),
    .score_out    (score_out),
    .score_valid  (score_valid),
    .frame_err    (frame_err),
    .busy         (busy)
  );

  always #5 pclk = ~pclk;

  // Frame-level reference: bytes collected so far and silent cycles since the last one.
  bit          m_in;
  int          m_n;
  logic [7:0]  m_buf [3];
  int          m_gap;
  logic [23:0] m_score;
  bit          m_valid, m_err;

  task automatic model_reset();
    m_in = 0; m_n = 0; m_gap = 0; m_score = 24'h000000; m_valid = 0; m_err = 0;
  endtask

  function automatic bit digits_ok(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
`ifdef SCORE_RX_BCD_CHECK_EN
    int v [3];
    v[0] = a; v[1] = b; v[2] = c;
    foreach (v[i]) if (v[i] / 16 > 9 || v[i] % 16 > 9) return 0;
`else
    if (a === 8'hxx && b === 8'hxx && c === 8'hxx) return 0;
`endif
    return 1;
  endfunction

  task automatic model_step(input bit tick, input logic [7:0] data);
    m_valid = 0; m_err = 0;
    if (!m_in) begin
      if (tick && data == 8'hA5) begin m_in = 1; m_n = 0; m_gap = 0; end
    end else if (tick) begin
      m_gap = 0;
      if (m_n < 3) begin
        m_buf[m_n] = data; m_n++;
      end else begin
        if (data == (m_buf[0] ^ m_buf[1] ^ m_buf[2]) && digits_ok(m_buf[0], m_buf[1], m_buf[2])) begin
          m_score = {m_buf[0], m_buf[1], m_buf[2]};
          m_valid = 1;
        end else begin
          m_err = 1;
        end
        m_in = 0;
      end
    end else begin
      m_gap++;
      if (m_gap == T) begin m_in = 0; m_err = 1; end
    end
  endtask

  task automatic check(input string name, input logic [23:0] s, input bit v, input bit e, input bit b);
    vectors++;
    if (score_out !== s || score_valid !== v || frame_err !== e || busy !== b) begin
      miscompares++;
      $display("FAIL %s t=%0t: got score=%h valid=%b err=%b busy=%b, want score=%h valid=%b err=%b busy=%b",
               name, $time, score_out, score_valid, frame_err, busy, s, v, e, b);
    end
  endtask

  task automatic step(input bit tick, input logic [7:0] data);
    rx_done_tick = tick;
    rx_data      = data;
    @(posedge pclk); #1;
    rx_done_tick = 1'b0;
    model_step(tick, data);
    check("model", m_score, m_valid, m_err, m_in);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    for (int i = 0; i < gap; i++) step(0, 8'h00);
    step(1, b);
  endtask

  typedef struct {
    bit          tick;
    logic [7:0]  data;
    logic [23:0] s;
    bit          v, e, b;
  } vec_t;

  vec_t tbl [$];

  task automatic add(input bit tk, input logic [7:0] d, input logic [23:0] s, input bit v, input bit e, input bit b);
    vec_t x;
    x.tick = tk; x.data = d; x.s = s; x.v = v; x.e = e; x.b = b;
    tbl.push_back(x);
  endtask

  logic [23:0] after_tbl;

  initial begin
    add(1, 8'hA5, 24'h000000, 0, 0, 1);
    add(1, 8'h12, 24'h000000, 0, 0, 1);
    add(1, 8'h34, 24'h000000, 0, 0, 1);
    add(1, 8'h56, 24'h000000, 0, 0, 1);
    add(1, 8'h70, 24'h123456, 1, 0, 0);
    add(0, 8'h00, 24'h123456, 0, 0, 0);
    add(1, 8'h00, 24'h123456, 0, 0, 0);
    add(1, 8'hFF, 24'h123456, 0, 0, 0);
    add(1, 8'hA5, 24'h123456, 0, 0, 1);
    add(1, 8'h00, 24'h123456, 0, 0, 1);
    add(1, 8'h01, 24'h123456, 0, 0, 1);
    add(1, 8'h23, 24'h123456, 0, 0, 1);
    add(1, 8'h22, 24'h000123, 1, 0, 0);
    add(1, 8'hA5, 24'h000123, 0, 0, 1);
    add(1, 8'h12, 24'h000123, 0, 0, 1);
    add(1, 8'h34, 24'h000123, 0, 0, 1);
    add(1, 8'h56, 24'h000123, 0, 0, 1);
    add(1, 8'h71, 24'h000123, 0, 1, 0);
    add(0, 8'h00, 24'h000123, 0, 0, 0);
    add(1, 8'hA5, 24'h000123, 0, 0, 1);
    add(1, 8'h1A, 24'h000123, 0, 0, 1);
    add(1, 8'h00, 24'h000123, 0, 0, 1);
    add(1, 8'h00, 24'h000123, 0, 0, 1);
`ifdef SCORE_RX_BCD_CHECK_EN
    add(1, 8'h1A, 24'h000123, 0, 1, 0);
    after_tbl = 24'h000123;
`else
    add(1, 8'h1A, 24'h1A0000, 1, 0, 0);
    after_tbl = 24'h1A0000;
`endif
    add(0, 8'h00, after_tbl, 0, 0, 0);

    model_reset();
    repeat (3) @(posedge pclk);
    #1;
    check("reset", 24'h000000, 0, 0, 0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      step(tbl[i].tick, tbl[i].data);
      check($sformatf("table[%0d]", i), tbl[i].s, tbl[i].v, tbl[i].e, tbl[i].b);
    end

    // Timeout: A5 12 then silence; expiry lands on the T-th silent cycle.
    step(1, 8'hA5);
    step(1, 8'h12);
    for (int i = 0; i < T - 1; i++) step(0, 8'h00);
    check("timeout_pre", after_tbl, 0, 0, 1);
    step(0, 8'h00);
    check("timeout_hit", after_tbl, 0, 1, 0);
    step(0, 8'h00);
    check("timeout_post", after_tbl, 0, 0, 0);
    step(1, 8'hA5); step(1, 8'h99); step(1, 8'h99); step(1, 8'h99); step(1, 8'h99);
    check("after_timeout", 24'h999999, 1, 0, 0);

    // Strobe arriving on the expiry cycle is kept.
    step(1, 8'hA5); step(1, 8'h12); step(1, 8'h34);
    for (int i = 0; i < T - 1; i++) step(0, 8'h00);
    step(1, 8'h56);
    check("strobe_wins", 24'h999999, 0, 0, 1);
    step(1, 8'h70);
    check("strobe_wins_done", 24'h123456, 1, 0, 0);

    // Asynchronous reset mid-frame.
    step(1, 8'hA5); step(1, 8'h12); step(1, 8'h34);
    #3 rst = 1'b1;
    #1 check("async_reset", 24'h000000, 0, 0, 0);
    model_reset();
    @(posedge pclk); #1 rst = 1'b0;
    step(1, 8'hA5); step(1, 8'h00); step(1, 8'h01); step(1, 8'h23); step(1, 8'h22);
    check("post_reset_frame", 24'h000123, 1, 0, 0);

    // Randomised frames, corruptions, junk and long gaps.
    for (int f = 0; f < 200; f++) begin
      int kind;
      logic [23:0] p;
      logic [7:0]  c;
      kind = $urandom_range(0, 4);
      p = 24'($urandom);
      if ($urandom_range(0, 1) == 1) p = p & 24'h777777;
      c = p[23:16] ^ p[15:8] ^ p[7:0];
      if (kind == 2) c = c ^ 8'($urandom_range(1, 255));
      if (kind <= 2) begin
        send_byte(8'hA5, $urandom_range(0, 3));
        send_byte(p[23:16], ($urandom_range(0, 9) == 0) ? $urandom_range(T - 2, T + 1) : $urandom_range(0, 3));
        send_byte(p[15:8],  ($urandom_range(0, 9) == 0) ? $urandom_range(T - 2, T + 1) : $urandom_range(0, 3));
        send_byte(p[7:0],   $urandom_range(0, 3));
        send_byte(c,        ($urandom_range(0, 9) == 0) ? $urandom_range(T - 2, T + 1) : $urandom_range(0, 3));
      end else if (kind == 3) begin
        send_byte(8'($urandom), $urandom_range(0, 3));
      end else begin
        send_byte(8'hA5, $urandom_range(0, 2));
        send_byte(8'hA5, $urandom_range(0, 2));
      end
    end
    for (int i = 0; i < T + 2; i++) step(0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
